// File: rtl/aud_recorder_multi_if.sv
// -----------------------------------------------------------------------------
// aud_recorder_multi_if
// SRAM write bus between the audio recorder and the sample memory.
//   o_address : word address, valid while o_we = 1
//   o_data    : sample word,  valid while o_we = 1
//   o_we      : one-cycle write strobe per committed word
// The recorder drives the bus through the master modport; the memory (or a
// bench monitor) observes it through the slave modport.
// -----------------------------------------------------------------------------
interface aud_recorder_multi_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) ();

  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_we;

  modport master (
    output o_address,
    output o_data,
    output o_we
  );

  modport slave (
    input o_address,
    input o_data,
    input o_we
  );

endinterface

// File: rtl/aud_recorder_multi.sv
// -----------------------------------------------------------------------------
// aud_recorder_multi
// I2S capture engine that records left, right or interleaved stereo samples
// into a word-addressed SRAM. Everything runs on the bit clock (i_clk).
//
// Ports
//   i_clk, i_rst             : bit clock, synchronous active-high reset
//   i_lrc, i_data            : I2S word select (0 = left) and serial data
//   i_start/i_pause/i_stop   : level-sampled controls, stop > pause > start
//   i_mode                   : 00 left, 01 right, 10 stereo, 11 acts as 00
//   i_wrap                   : 1 = wrap at end of memory, 0 = stop when full
//   wr                       : SRAM write bus (o_address, o_data, o_we)
//   o_len                    : words written since last start, saturating
//   o_busy, o_full, o_err    : recording active / memory full / sticky
//                              framing error
// -----------------------------------------------------------------------------
module aud_recorder_multi #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_lrc,
  input  logic                 i_data,
  input  logic                 i_start,
  input  logic                 i_pause,
  input  logic                 i_stop,
  input  logic [1:0]           i_mode,
  input  logic                 i_wrap,
  aud_recorder_multi_if.master wr,
  output logic [ADDR_W:0]      o_len,
  output logic                 o_busy,
  output logic                 o_full,
  output logic                 o_err
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_END = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EDGE = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_HOLD      = 3'd3,
    ST_PAUSE     = 3'd4,
    ST_FULL      = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              lrc_q;                 // i_lrc delayed one bit clock
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              we_q,    we_d;
  logic [ADDR_W:0]   len_q,   len_d;
  logic              busy_q,  busy_d;
  logic              full_q,  full_d;
  logic              err_q,   err_d;
  logic [1:0]        mode_q,  mode_d;
  logic              wrap_q,  wrap_d;

  logic edge_s;
  logic left_edge_s;
  logic right_edge_s;
  logic stereo_s;
  logic mono_right_s;
  logic accept_s;
  logic word_done_s;
  logic at_end_s;
  logic start_clr_s;
  logic err_set_s;
  logic restart_s;

  // Channel-edge and status decode shared by the FSM and the datapath.
  always_comb begin
    edge_s       = i_lrc ^ lrc_q;
    left_edge_s  = edge_s & ~i_lrc;
    right_edge_s = edge_s &  i_lrc;
    stereo_s     = (mode_q == 2'b10);
    mono_right_s = (mode_q == 2'b01);
    word_done_s  = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
    at_end_s     = (addr_q == ADDR_END);
  end

  // Decide whether this cycle's edge opens a channel we record.
  // In stereo a fresh start or resume only locks onto a left edge so the
  // stream stays L,R ordered; once locked every edge alternates channel.
  always_comb begin
    accept_s = 1'b0;
    if (stereo_s) begin
      if ((state_q == ST_SHIFT) || (state_q == ST_HOLD)) begin
        accept_s = edge_s;
      end else begin
        accept_s = left_edge_s;
      end
    end else if (mono_right_s) begin
      accept_s = right_edge_s;
    end else begin
      accept_s = left_edge_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; stop beats pause beats start in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_start) begin
          state_d = ST_WAIT_EDGE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_start) begin
          state_d = ST_WAIT_EDGE;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_PAUSE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_start) begin
          state_d = ST_WAIT_EDGE;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_WAIT_EDGE, ST_HOLD: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else if (accept_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = state_q;
        end
      end
      ST_SHIFT: begin
        // An edge on the last-bit cycle is the normal I2S case (the LSB
        // trails the word select by one bit); earlier it is a framing error.
        // Either way an accepted edge is the delay bit of the next word.
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (word_done_s && at_end_s && !wrap_q) begin
          state_d = ST_FULL;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else if (edge_s) begin
          state_d = accept_s ? ST_SHIFT : ST_HOLD;
        end else if (word_done_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, computed from the next state so the flops line up with it.
  always_comb begin
    busy_d = 1'b0;
    full_d = 1'b0;
    case (state_d)
      ST_WAIT_EDGE, ST_SHIFT, ST_HOLD: begin
        busy_d = 1'b1;
      end
      ST_FULL: begin
        full_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        full_d = 1'b0;
      end
    endcase
  end

  // Datapath next values: shifter, commit, address/length, error, config.
  always_comb begin
    start_clr_s = ((state_q == ST_IDLE) || (state_q == ST_FULL)) && i_start && !i_stop;
    err_set_s   = (state_q == ST_SHIFT) && edge_s && !word_done_s && !i_stop && !i_pause;
    // A new word starts on the delay-bit cycle: entering SHIFT, or an edge
    // seen while already shifting.
    restart_s   = (state_d == ST_SHIFT) && ((state_q != ST_SHIFT) || edge_s);

    if (restart_s) begin
      shift_d = {DATA_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else if (state_d == ST_SHIFT) begin
      shift_d = {shift_q[DATA_W-2:0], i_data};
      cnt_d   = cnt_q + CNT_W'(1);
    end else begin
      shift_d = {DATA_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end

    // The final bit is committed even if stop, pause or full hit this cycle.
    if (word_done_s) begin
      data_d = {shift_q[DATA_W-2:0], i_data};
      we_d   = 1'b1;
    end else begin
      data_d = data_q;
      we_d   = 1'b0;
    end

    // Address advances once the strobe has been seen by the memory.
    if (start_clr_s) begin
      addr_d = {ADDR_W{1'b0}};
      len_d  = {(ADDR_W+1){1'b0}};
    end else if (we_q) begin
      addr_d = (at_end_s && !wrap_q) ? addr_q : (addr_q + ADDR_W'(1));
      len_d  = (len_q == LEN_MAX) ? len_q : (len_q + (ADDR_W+1)'(1));
    end else begin
      addr_d = addr_q;
      len_d  = len_q;
    end

    if (start_clr_s) begin
      err_d = 1'b0;
    end else if (err_set_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (start_clr_s) begin
      mode_d = (i_mode == 2'b11) ? 2'b00 : i_mode;
      wrap_d = i_wrap;
    end else begin
      mode_d = mode_q;
      wrap_d = wrap_q;
    end
  end

  // Datapath and registered-output flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lrc_q   <= 1'b0;
      shift_q <= {DATA_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      data_q  <= {DATA_W{1'b0}};
      we_q    <= 1'b0;
      len_q   <= {(ADDR_W+1){1'b0}};
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 2'b00;
      wrap_q  <= 1'b0;
    end else begin
      lrc_q   <= i_lrc;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wr.o_address = addr_q;
  assign wr.o_data    = data_q;
  assign wr.o_we      = we_q;
  assign o_len        = len_q;
  assign o_busy       = busy_q;
  assign o_full       = full_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_aud_recorder_multi.sv
// -----------------------------------------------------------------------------
// tb_aud_recorder_multi
// Scoreboard bench for aud_recorder_multi (DATA_W=16, ADDR_W=4). An I2S frame
// task drives 32-BCLK frames and one optional control event per frame; the
// expected SRAM writes are queued as the frames are driven and popped by a
// write monitor whenever o_we is seen.
// -----------------------------------------------------------------------------
module tb_aud_recorder_multi;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam int EV_NONE   = 0;
  localparam int EV_START  = 1;
  localparam int EV_PAUSE  = 2;
  localparam int EV_STOP   = 3;
  localparam int EV_RST    = 4;
  localparam int EV_GLITCH = 5;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_lrc = 1'b1;
  logic            i_data = 1'b0;
  logic            i_start = 1'b0;
  logic            i_pause = 1'b0;
  logic            i_stop = 1'b0;
  logic [1:0]      i_mode = 2'b00;
  logic            i_wrap = 1'b0;
  logic [ADDR_W:0] o_len;
  logic            o_busy;
  logic            o_full;
  logic            o_err;

  int   n_vec  = 0;
  int   n_miss = 0;
  logic prev_r0 = 1'b0;

  int exp_addr_q[$];
  int exp_data_q[$];

  aud_recorder_multi_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wr_if ();

  aud_recorder_multi #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_lrc   (i_lrc),
    .i_data  (i_data),
    .i_start (i_start),
    .i_pause (i_pause),
    .i_stop  (i_stop),
    .i_mode  (i_mode),
    .i_wrap  (i_wrap),
    .wr      (wr_if),
    .o_len   (o_len),
    .o_busy  (o_busy),
    .o_full  (o_full),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input int addr, input int data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr"}, 32'(wr_if.o_address), 32'd0);
    check_eq({tag, "_data"}, 32'(wr_if.o_data), 32'd0);
    check_eq({tag, "_we"},   32'(wr_if.o_we), 32'd0);
    check_eq({tag, "_len"},  32'(o_len), 32'd0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_full"}, 32'(o_full), 32'd0);
    check_eq({tag, "_err"},  32'(o_err), 32'd0);
  endtask

  // One 32-BCLK I2S frame: left half k=0..15, right half k=16..31, each word
  // MSB first starting one bit after its word-select edge. ev_kind fires at
  // k == ev_pos (a glitch moves the left->right switch to ev_pos instead).
  task automatic frame(input logic [15:0] l, input logic [15:0] r,
                       input int ev_pos, input int ev_kind);
    int lrc_switch;
    lrc_switch = (ev_kind == EV_GLITCH) ? ev_pos : 16;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if ((ev_kind == EV_RST) && (k == ev_pos + 1)) begin
        check_all_zero("rst_mid_word");
      end
      i_start = 1'b0;
      i_pause = 1'b0;
      i_stop  = 1'b0;
      i_rst   = 1'b0;
      i_lrc   = (k >= lrc_switch) ? 1'b1 : 1'b0;
      if (k == 0) begin
        i_data = prev_r0;
      end else if (k <= 16) begin
        i_data = l[4'(16 - k)];
      end else begin
        i_data = r[4'(32 - k)];
      end
      if (k == ev_pos) begin
        case (ev_kind)
          EV_START: i_start = 1'b1;
          EV_PAUSE: i_pause = 1'b1;
          EV_STOP:  i_stop  = 1'b1;
          EV_RST:   i_rst   = 1'b1;
          default:  ;
        endcase
      end
    end
    prev_r0 = r[0];
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  initial begin
    int ea;
    int ed;
    forever begin
      @(posedge clk);
      #1;
      if (wr_if.o_we === 1'b1) begin
        if (exp_data_q.size() == 0) begin
          check_eq("unexpected_we", 32'(wr_if.o_we), 32'd0);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check_eq("wr_addr", 32'(wr_if.o_address), 32'(ea));
          check_eq("wr_data", 32'(wr_if.o_data), 32'(ed));
        end
      end
    end
  end

  initial begin
    // Reset state
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_rst = 1'b0;

    // Mono left: only left words land, in order
    i_mode = 2'b00;
    i_wrap = 1'b0;
    frame(16'h0000, 16'h0000, 20, EV_START);
    sb_push(0, 16'hA5C3);
    sb_push(1, 16'h1234);
    frame(16'hA5C3, 16'hBEEF, -1, EV_NONE);
    frame(16'h1234, 16'h5678, -1, EV_NONE);
    check_eq("mono_len", 32'(o_len), 32'd2);
    check_eq("mono_busy", 32'(o_busy), 32'd1);
    frame(16'h0000, 16'h0000, 5, EV_STOP);
    check_eq("stop_busy", 32'(o_busy), 32'd0);
    check_eq("stop_len_kept", 32'(o_len), 32'd2);
    check_eq("stop_addr_kept", 32'(wr_if.o_address), 32'd2);

    // Stereo, started in the middle of a right half
    i_mode = 2'b10;
    frame(16'h0000, 16'h0000, 20, EV_START);
    check_eq("start_clr_len", 32'(o_len), 32'd0);
    sb_push(0, 16'h1111);
    sb_push(1, 16'h2222);
    frame(16'h1111, 16'h2222, -1, EV_NONE);
    frame(16'h0000, 16'h0000, 3, EV_STOP);
    check_eq("stereo_len", 32'(o_len), 32'd2);
    check_eq("stereo_err", 32'(o_err), 32'd0);

    // Full boundary without wrap: 17 words, 16 writes
    i_mode = 2'b00;
    i_wrap = 1'b0;
    frame(16'h0000, 16'h0000, 20, EV_START);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb_push(i, 16'hC000 + i);
      frame(16'hC000 + 16'(i), 16'h7E7E, -1, EV_NONE);
    end
    check_eq("nowrap_full", 32'(o_full), 32'd1);
    check_eq("nowrap_len", 32'(o_len), 32'd16);
    check_eq("nowrap_busy", 32'(o_busy), 32'd0);

    // Same with wrap: 17th word lands at address 0, length saturates
    i_wrap = 1'b1;
    frame(16'h0000, 16'h0000, 20, EV_START);
    check_eq("restart_full_clr", 32'(o_full), 32'd0);
    for (int i = 0; i < 17; i++) begin
      sb_push(i % 16, 16'hD000 + i);
      frame(16'hD000 + 16'(i), 16'h7E7E, -1, EV_NONE);
    end
    check_eq("wrap_len", 32'(o_len), 32'd16);
    check_eq("wrap_full", 32'(o_full), 32'd0);
    check_eq("wrap_addr", 32'(wr_if.o_address), 32'd1);
    frame(16'h0000, 16'h0000, 5, EV_STOP);

    // Pause after bit 5 of word 2, resume writes the next word at address 1
    i_wrap = 1'b0;
    frame(16'h0000, 16'h0000, 20, EV_START);
    sb_push(0, 16'h4B1D);
    frame(16'h4B1D, 16'h0000, -1, EV_NONE);
    frame(16'h9999, 16'h0000, 6, EV_PAUSE);
    check_eq("pause_busy", 32'(o_busy), 32'd0);
    check_eq("pause_len", 32'(o_len), 32'd1);
    frame(16'hAAAA, 16'h0000, 20, EV_START);
    sb_push(1, 16'h5EED);
    frame(16'h5EED, 16'h0000, -1, EV_NONE);
    check_eq("resume_len", 32'(o_len), 32'd2);
    frame(16'h0000, 16'h0000, 5, EV_STOP);

    // Framing error (reserved mode 11 behaves as left only)
    i_mode = 2'b11;
    frame(16'h0000, 16'h0000, 20, EV_START);
    frame(16'hF00D, 16'h0000, 11, EV_GLITCH);
    check_eq("ferr_err", 32'(o_err), 32'd1);
    check_eq("ferr_len", 32'(o_len), 32'd0);
    sb_push(0, 16'h0ABC);
    frame(16'h0ABC, 16'h0000, -1, EV_NONE);
    check_eq("ferr_sticky", 32'(o_err), 32'd1);
    check_eq("ferr_next_len", 32'(o_len), 32'd1);
    frame(16'h0000, 16'h0000, 5, EV_STOP);
    check_eq("ferr_after_stop", 32'(o_err), 32'd1);
    frame(16'h0000, 16'h0000, 20, EV_START);
    check_eq("ferr_cleared", 32'(o_err), 32'd0);
    frame(16'h0000, 16'h0000, 5, EV_STOP);

    // Reset in the middle of a right word (mono right)
    i_mode = 2'b01;
    frame(16'h0000, 16'h0000, 20, EV_START);
    sb_push(0, 16'h3C3C);
    frame(16'h1111, 16'h3C3C, -1, EV_NONE);
    frame(16'h2222, 16'h7777, 25, EV_RST);

    repeat (4) @(negedge clk);
    check_eq("sb_drained", 32'(exp_data_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aud_recorder_multi.md
AUD_RECORDER_MULTI -- requirements
Module: aud_recorder_multi

Interface
REQ-001 SHALL have parameter DATA_W, 16, bits per captured sample (2..32).
REQ-002 SHALL have parameter ADDR_W, 20, SRAM word-address width; depth = 2**ADDR_W words.
REQ-003 SHALL have port i_clk  in  1  audio bit clock (BCLK); all logic on its rising edge; single clock domain.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_lrc  in  1  channel select; 0 = left, 1 = right.
REQ-006 SHALL have port i_data  in  1  serial audio data, MSB first.
REQ-007 SHALL have ports i_start, i_pause, i_stop  in  1 each  level-sampled control pulses.
REQ-008 SHALL have port i_mode  in  2  00 = left only, 01 = right only, 10 = stereo interleaved, 11 = reserved (treated as 00).
REQ-009 SHALL have port i_wrap  in  1  1 = wrap at end of memory, 0 = stop when full.
REQ-010 SHALL have port o_address  out  ADDR_W  write address, valid while o_we = 1.
REQ-011 SHALL have port o_data  out  DATA_W  write data, valid while o_we = 1.
REQ-012 SHALL have port o_we  out  1  one-cycle write strobe per committed word.
REQ-013 SHALL have port o_len  out  ADDR_W+1  words written since last start; saturates at 2**ADDR_W.
REQ-014 SHALL have ports o_busy, o_full, o_err  out  1 each  recording active / memory full / sticky framing error.

Function
REQ-015 SHALL implement states IDLE, WAIT_EDGE, SHIFT, HOLD, PAUSE, FULL.
REQ-016 SHALL register i_lrc into lrc_d; a channel edge is a cycle where i_lrc != lrc_d.
REQ-017 SHALL apply control priority i_stop > i_pause > i_start in every state.
REQ-018 SHALL, on i_start in IDLE or FULL, latch i_mode and i_wrap, clear the address, o_len and o_err, and enter WAIT_EDGE.
REQ-019 SHALL leave WAIT_EDGE and HOLD on an edge into an accepted channel: left edge (1->0) only in stereo mode; the selected channel in mono; any edge alternating L/R after the first left in stereo.
REQ-020 SHALL treat the edge cycle as the I2S delay bit; the DATA_W cycles that follow SHALL be shifted in MSB first in SHIFT.
REQ-021 SHALL, on the cycle the last bit is sampled, register the assembled word to o_data, drive the current address onto o_address, assert o_we for the next cycle only, and enter HOLD.
REQ-022 SHALL increment the address and o_len on the cycle after o_we.
REQ-023 SHALL, when the word at address 2**ADDR_W-1 is committed, wrap the address to 0 if i_wrap was latched 1, else enter FULL with o_full = 1 and no further writes.
REQ-024 SHALL, on a channel edge during SHIFT before DATA_W bits are collected, discard the partial word, set o_err (sticky), and handle the edge as in REQ-019.
REQ-025 SHALL, on i_pause in SHIFT, discard the partial word and enter PAUSE; a word completing in the same cycle SHALL still be committed.
REQ-026 SHALL, on i_start in PAUSE, enter WAIT_EDGE; in stereo, resume SHALL wait for a left edge so pairs stay L,R aligned.
REQ-027 SHALL, on i_stop in any state, enter IDLE, retain o_len and o_address, and still commit a word completing in that cycle.
REQ-028 SHALL hold o_busy = 1 in WAIT_EDGE, SHIFT and HOLD, and 0 in all other states.
REQ-029 SHALL ignore i_pause outside SHIFT/HOLD/WAIT_EDGE and i_start outside IDLE/FULL/PAUSE.

Reset
REQ-030 SHALL, on i_rst = 1 at a rising i_clk, set state IDLE, lrc_d 0, shift register 0, bit counter 0, o_address 0, o_data 0, o_we 0, o_len 0, o_busy 0, o_full 0, o_err 0.
REQ-031 SHALL, when reset asserts mid-word, drop the word without asserting o_we, regardless of other inputs.

Verification (DATA_W=16, ADDR_W=4, 32-BCLK frames)
REQ-032 SHALL cover mono left: i_mode=00, left words 0xA5C3 and 0x1234 -> o_we twice, address 0 data 0xA5C3 then address 1 data 0x1234, right words never written, o_len=2.
REQ-033 SHALL cover stereo: start mid right half, L=0x1111 R=0x2222 -> first write is 0x1111 at address 0, then 0x2222 at address 1.
REQ-034 SHALL cover the full boundary: i_wrap=0, 17 words -> 16 writes (address 0..15), o_full=1, o_len=16, 17th word not written; repeat with i_wrap=1 -> 17th word at address 0, o_len=16.
REQ-035 SHALL cover pause: i_pause after bit 5 of word 2 -> no write for word 2; i_start then writes the next full word at address 1.
REQ-036 SHALL cover framing error: lrc edge after 10 bits -> no o_we, o_err=1 until the next i_start.
REQ-037 SHALL cover reset mid-word: i_rst at bit 8 -> all outputs 0 next cycle, no o_we.
